v74x148_req_encoder: RTL and testbench

- Sequential 8-line priority encoder, the encoding counterpart of the lab's 74x139-style active-low decoders.
- Captures falling edges on active-low request lines into a pending set.
- Presents the highest-index pending request as a binary code with a VALID/ACK handshake.
- Clears each request once it is acknowledged.
- Group-select and enable-out keep 74x148-style cascade semantics.

---
 rtl/v74x148_req_encoder.sv | 96 +++++++++
 tb/tb_v74x148_req_encoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/v74x148_req_encoder.sv
// Edge-captured 8-line priority request encoder with VALID/ACK handshake.
// Define V74X148_LEVEL_EN for level-sensitive requests that ACK does not clear.
module v74x148_req_encoder #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EI_L,
  input  logic [N-1:0]  I_L,
  input  logic          ACK,
  output logic [AW-1:0] A,
  output logic          VALID,
  output logic          GS_L,
  output logic          EO_L
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  pending;
  logic [N-1:0]  pending_nxt;
  logic [AW-1:0] a_nxt;
  logic [AW-1:0] top_idx;
  logic          valid_nxt;

`ifdef V74X148_LEVEL_EN
  always_comb begin
    pending_nxt = ~I_L;
  end
`else
  logic [N-1:0] s;
  logic [N-1:0] clr_mask;

  always_ff @(posedge CLK) begin
    if (RESET) s <= '1;
    else       s <= I_L;
  end

  // a fresh falling edge beats the ACK clear on the same bit
  always_comb begin
    clr_mask = '0;
    if (state == PRESENT && ACK) clr_mask[A] = 1'b1;
    pending_nxt = (pending & ~clr_mask) | (s & ~I_L);
  end
`endif

  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++)
      if (pending[i]) top_idx = AW'(i);
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = A;
    valid_nxt = VALID;
    unique case (state)
      IDLE: begin
        if (!EI_L && |pending) begin
          a_nxt     = top_idx;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ACK) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      pending <= '0;
      A       <= '0;
      VALID   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      A       <= a_nxt;
      VALID   <= valid_nxt;
    end
  end

  assign GS_L = ~(~EI_L & (|pending));
  assign EO_L = ~(~EI_L & ~(|pending));

endmodule

// File: tb/tb_v74x148_req_encoder.sv
// Self-checking bench: directed literal checks plus randomized traffic
// compared every cycle against a behavioural request-set model.
module tb_v74x148_req_encoder;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          CLK;
  logic          RESET;
  logic          EI_L;
  logic [N-1:0]  I_L;
  logic          ACK;
  logic [AW-1:0] A;
  logic          VALID;
  logic          GS_L;
  logic          EO_L;

  int tests;
  int fails;

  v74x148_req_encoder #(.N(N), .AW(AW)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .EI_L (EI_L),
    .I_L  (I_L),
    .ACK  (ACK),
    .A    (A),
    .VALID(VALID),
    .GS_L (GS_L),
    .EO_L (EO_L)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // model: set of outstanding requests, previous line levels, current offer
  bit        m_req [N];
  bit        m_prev[N];
  bit        m_busy;
  int        m_code;

  function automatic int highest_req();
    for (int i = N - 1; i >= 0; i--)
      if (m_req[i]) return i;
    return -1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  top;
    bit  old_req[N];
    if (RESET) begin
      for (int i = 0; i < N; i++) begin
        m_req[i]  = 1'b0;
        m_prev[i] = 1'b1;
      end
      m_busy = 1'b0;
      m_code = 0;
      return;
    end
    old_req = m_req;
    top = -1;
    for (int i = N - 1; i >= 0; i--)
      if (old_req[i] && top < 0) top = i;
`ifdef V74X148_LEVEL_EN
    for (int i = 0; i < N; i++) m_req[i] = !I_L[i];
`else
    if (m_busy && ACK) m_req[m_code] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_prev[i] && !I_L[i]) m_req[i] = 1'b1;
      m_prev[i] = I_L[i];
    end
`endif
    if (m_busy) begin
      if (ACK) m_busy = 1'b0;
    end else if (!EI_L && top >= 0) begin
      m_code = top;
      m_busy = 1'b1;
    end
  endtask

  always @(posedge CLK) begin
    bit any;
    model_edge();
    #1;
    any = (highest_req() >= 0);
    check("valid", 32'(VALID), 32'(m_busy));
    check("code", 32'(A), 32'(m_code));
    check("gs_l", 32'(GS_L), 32'(!(!EI_L && any)));
    check("eo_l", 32'(EO_L), 32'(!(!EI_L && !any)));
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESET = 1'b1;
    EI_L  = 1'b0;
    I_L   = 8'hFF;
    ACK   = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(VALID), 32'd0);
    check("rst_a", 32'(A), 32'd0);
    check("rst_gs", 32'(GS_L), 32'd1);
    check("rst_eo", 32'(EO_L), 32'd0);
    RESET = 1'b0;
    tick();

`ifndef V74X148_LEVEL_EN
    // single request, held low after ACK
    I_L = 8'hDF;
    tick();
    check("single_gs", 32'(GS_L), 32'd0);
    check("single_v0", 32'(VALID), 32'd0);
    tick();
    check("single_v", 32'(VALID), 32'd1);
    check("single_a", 32'(A), 32'd5);
    tick();
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("single_ack_v", 32'(VALID), 32'd0);
    check("single_ack_gs", 32'(GS_L), 32'd1);
    check("single_ack_eo", 32'(EO_L), 32'd0);
    tick();
    tick();
    check("single_norepeat", 32'(VALID), 32'd0);
    I_L = 8'hFF;
    tick();

    // priority
    I_L = 8'hBB;
    tick();
    tick();
    check("prio_a6", 32'(A), 32'd6);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("prio_gap", 32'(VALID), 32'd0);
    tick();
    check("prio_a2", 32'(A), 32'd2);
    check("prio_v2", 32'(VALID), 32'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check("prio_empty_gs", 32'(GS_L), 32'd1);
    I_L = 8'hFF;
    tick();

    // no preemption, then set-wins on the ACK edge
    I_L = 8'hFD;
    tick();
    tick();
    check("np_a1", 32'(A), 32'd1);
    I_L = 8'h7D;
    tick();
    tick();
    check("np_hold", 32'(A), 32'd1);
    I_L = 8'h7F;
    tick();
    ACK = 1'b1;
    I_L = 8'h7D;
    tick();
    ACK = 1'b0;
    tick();
    check("np_a7", 32'(A), 32'd7);
    check("np_v7", 32'(VALID), 32'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    tick();
    check("sw_a1", 32'(A), 32'd1);
    check("sw_v1", 32'(VALID), 32'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    I_L = 8'hFF;
    tick();
    check("sw_empty", 32'(GS_L), 32'd1);

    // enable gating
    EI_L = 1'b1;
    I_L  = 8'hF7;
    tick();
    tick();
    check("en_v", 32'(VALID), 32'd0);
    check("en_gs", 32'(GS_L), 32'd1);
    check("en_eo", 32'(EO_L), 32'd1);
    EI_L = 1'b0;
    #1;
    check("en_gs_now", 32'(GS_L), 32'd0);
    tick();
    check("en_a3", 32'(A), 32'd3);
    check("en_v3", 32'(VALID), 32'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    I_L = 8'hFF;
    tick();

    // reset mid-presentation
    I_L = 8'hEF;
    tick();
    tick();
    check("mr_a4", 32'(A), 32'd4);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("mr_v", 32'(VALID), 32'd0);
    check("mr_gs", 32'(GS_L), 32'd1);
    tick();
    check("mr_recap", 32'(GS_L), 32'd0);
    tick();
    check("mr_a4b", 32'(A), 32'd4);
    check("mr_v4b", 32'(VALID), 32'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    I_L = 8'hFF;
    tick();
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        I_L = I_L ^ (8'(1) << $urandom_range(0, N - 1));
      EI_L  = ($urandom_range(0, 7) == 0);
      ACK   = ($urandom_range(0, 2) == 0);
      RESET = ($urandom_range(0, 199) == 0);
      tick();
    end
    RESET = 1'b0;
    ACK   = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
